// File: rtl/priority_arbiter_4.sv
// 4-requester arbiter with registered one-hot grant and optional hold-limit timeout.
// Define ROUND_ROBIN_EN for rotating priority; default is fixed priority req[3] highest.
module priority_arbiter_4 #(
   parameter int MAX_HOLD = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   output logic [3:0] gnt,
   output logic [1:0] gnt_id,
   output logic       gnt_valid,
   output logic       timeout
);

   localparam int CW_RAW = $clog2(MAX_HOLD + 1);
   localparam int CW = (CW_RAW < 1) ? 1 : CW_RAW;
   localparam bit LIMITED = (MAX_HOLD > 0);
   localparam logic [CW-1:0] LAST = CW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t        state_q, state_d;
   logic [3:0]    gnt_q, gnt_d;
   logic [1:0]    last_id_q, last_id_d;
   logic [CW-1:0] hold_cnt_q, hold_cnt_d;
   logic [3:0]    mask_q, mask_d;
   logic          timeout_q, timeout_d;

   logic [3:0] cand;
   logic [1:0] win;
   logic       owner_req;
   logic       expire;

   assign cand      = req & ~mask_q;
   assign owner_req = req[last_id_q];
   assign expire    = LIMITED && (hold_cnt_q == LAST);

`ifdef ROUND_ROBIN_EN
   logic [1:0] start;
   logic [1:0] idx;
   logic       found;

   // Search descends from the requester just below the previous winner.
   always_comb begin
      start = last_id_q - 2'd1;
      win   = start;
      found = 1'b0;
      idx   = start;
      for (int k = 0; k < 4; k++) begin
         idx = start - 2'(k);
         if (!found && cand[idx]) begin
            win   = idx;
            found = 1'b1;
         end
      end
   end
`else
   always_comb begin
      if (cand[3])      win = 2'd3;
      else if (cand[2]) win = 2'd2;
      else if (cand[1]) win = 2'd1;
      else              win = 2'd0;
   end
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         gnt_q      <= '0;
         last_id_q  <= '0;
         hold_cnt_q <= '0;
         mask_q     <= '0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         last_id_q  <= last_id_d;
         hold_cnt_q <= hold_cnt_d;
         mask_q     <= mask_d;
         timeout_q  <= timeout_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (|cand) state_d = GRANT;
         GRANT:   if (!owner_req || expire) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      gnt_d      = gnt_q;
      last_id_d  = last_id_q;
      hold_cnt_d = hold_cnt_q;
      mask_d     = mask_q;
      timeout_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (|cand) begin
               gnt_d      = 4'b0001 << win;
               last_id_d  = win;
               hold_cnt_d = '0;
               mask_d     = '0;
            end else if (|req) begin
               // Only the timed-out requester is asking: let it back in.
               mask_d = '0;
            end
         end
         GRANT: begin
            if (!owner_req) begin
               gnt_d = '0;
            end else if (expire) begin
               gnt_d     = '0;
               timeout_d = 1'b1;
               mask_d    = gnt_q;
            end else if (hold_cnt_q != '1) begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
         end
         default: gnt_d = '0;
      endcase
   end

   always_comb begin
      gnt       = gnt_q;
      gnt_id    = last_id_q;
      gnt_valid = |gnt_q;
      timeout   = timeout_q;
   end

endmodule

// File: tb/tb_priority_arbiter_4.sv
// Scoreboard bench for priority_arbiter_4 with a short hold limit.
// Expected grants are pushed per driven cycle and popped after the edge.
module tb_priority_arbiter_4;

   logic       clk;
   logic       rst_n;
   logic [3:0] req;
   logic [3:0] gnt;
   logic [1:0] gnt_id;
   logic       gnt_valid;
   logic       timeout;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [3:0] gnt;
      logic       to;
      string      tag;
   } exp_t;

   exp_t sb[$];

   priority_arbiter_4 #(.MAX_HOLD(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .gnt       (gnt),
      .gnt_id    (gnt_id),
      .gnt_valid (gnt_valid),
      .timeout   (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got,
                        input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [1:0] enc(input logic [3:0] oh);
      logic [1:0] r;
      r = 2'd0;
      for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
      return r;
   endfunction

   task automatic step(input logic rst, input logic [3:0] r,
                       input logic [3:0] eg, input logic eto,
                       input string tag);
      exp_t e;
      sb.push_back('{gnt: eg, to: eto, tag: tag});
      rst_n = rst;
      req   = r;
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         check({tag, " sb"}, 8'd0, 8'd1);
      end else begin
         e = sb.pop_front();
         check({e.tag, " gnt"}, {4'd0, gnt}, {4'd0, e.gnt});
         check({e.tag, " vld"}, {7'd0, gnt_valid}, {7'd0, |e.gnt});
         check({e.tag, " to"}, {7'd0, timeout}, {7'd0, e.to});
         if (e.gnt != 4'd0)
            check({e.tag, " id"}, {6'd0, gnt_id}, {6'd0, enc(e.gnt)});
      end
   endtask

   int ids[5];
   logic [3:0] t3n;

   initial begin
      rst_n = 1'b0;
      req   = 4'b1111;
`ifdef ROUND_ROBIN_EN
      ids = '{3, 2, 1, 0, 3};
      t3n = 4'b0010;
`else
      ids = '{3, 2, 3, 2, 3};
      t3n = 4'b1000;
`endif
      step(0, 4'b1111, 4'b0000, 0, "rst0");
      step(0, 4'b1111, 4'b0000, 0, "rst1");

      step(1, 4'b1001, 4'b1000, 0, "t2g");
      step(1, 4'b0000, 4'b0000, 0, "t2r");

      step(1, 4'b0110, 4'b0100, 0, "t3g");
      step(1, 4'b1110, 4'b0100, 0, "t3h");
      step(1, 4'b1010, 4'b0000, 0, "t3r");
      step(1, 4'b1010, t3n,     0, "t3n");
      step(1, 4'b0000, 4'b0000, 0, "t3i");

      step(1, 4'b0010, 4'b0010, 0, "simg");
      step(1, 4'b1000, 4'b0000, 0, "simr");
      step(1, 4'b1000, 4'b1000, 0, "simn");
      step(1, 4'b0000, 4'b0000, 0, "simi");

      step(0, 4'b0000, 4'b0000, 0, "rsa");
      for (int i = 0; i < 4; i++) step(1, 4'b0011, 4'b0010, 0, "t4h");
      step(1, 4'b0011, 4'b0000, 1, "t4to");
      step(1, 4'b0011, 4'b0001, 0, "t4n");
      step(1, 4'b0000, 4'b0000, 0, "t4i");

      for (int i = 0; i < 4; i++) step(1, 4'b0100, 4'b0100, 0, "soh");
      step(1, 4'b0100, 4'b0000, 1, "soto");
      step(1, 4'b0100, 4'b0000, 0, "sogap");
      step(1, 4'b0100, 4'b0100, 0, "sore");
      step(1, 4'b0000, 4'b0000, 0, "soi");

      step(0, 4'b0000, 4'b0000, 0, "rsb");
      for (int i = 0; i < 4; i++) step(1, 4'b1100, 4'b1000, 0, "fp3");
      step(1, 4'b1100, 4'b0000, 1, "fpto3");
      for (int i = 0; i < 4; i++) step(1, 4'b1100, 4'b0100, 0, "fp2");
      step(1, 4'b1100, 4'b0000, 1, "fpto2");
      step(1, 4'b1100, 4'b1000, 0, "fpb3");
      step(1, 4'b0000, 4'b0000, 0, "fpi");

      step(1, 4'b0100, 4'b0100, 0, "t6g");
      step(1, 4'b0100, 4'b0100, 0, "t6h");
      step(0, 4'b0100, 4'b0000, 0, "t6rst");
      for (int i = 0; i < 4; i++) step(1, 4'b0100, 4'b0100, 0, "t6re");
      step(1, 4'b0100, 4'b0000, 1, "t6to");
      step(1, 4'b0000, 4'b0000, 0, "t6i");

      step(0, 4'b0000, 4'b0000, 0, "rsc");
      for (int g = 0; g < 5; g++) begin
         for (int i = 0; i < 4; i++)
            step(1, 4'b1111, 4'b0001 << ids[g], 0, "t5g");
         if (g < 4) step(1, 4'b1111, 4'b0000, 1, "t5to");
      end
      step(1, 4'b0000, 4'b0000, 0, "t5i");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
